// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the receive state encoding.
// No timing of its own; constants only.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous level input; 2 clk latency.
// No backpressure; reset value selectable so idle-high lines stay quiet.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive bit timing: start detect, mid-bit sampling, stop check; outputs registered.
// First shift ~2 sync clks + 1.5 bit periods after the start edge; no backpressure (rx_sipo always accepts).
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_line,
  input  logic baud_tick,
  output logic rx_bit,
  output logic shift,
  output logic frame_done,
  output logic framing_err,
  output logic busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t     state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic          rx_bit_nxt, shift_nxt, done_nxt, err_nxt, busy_nxt;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_line),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RX_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      rx_bit      <= 1'b1;
      shift       <= 1'b0;
      frame_done  <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= tick_nxt;
      bit_cnt     <= bit_nxt;
      rx_bit      <= rx_bit_nxt;
      shift       <= shift_nxt;
      frame_done  <= done_nxt;
      framing_err <= err_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick_cnt;
    bit_nxt    = bit_cnt;
    rx_bit_nxt = rx_bit;
    shift_nxt  = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;

    unique case (state)
      RX_IDLE: begin
        if (baud_tick && !rx_s) begin
          state_nxt = RX_START;
          tick_nxt  = '0;
        end
      end

      // Re-check the line half a bit in; a high here was only a glitch.
      RX_START: begin
        if (baud_tick) begin
          if (tick_cnt == T_MID) begin
            tick_nxt = '0;
            if (!rx_s) begin
              state_nxt = RX_DATA;
              bit_nxt   = '0;
            end else begin
              state_nxt = RX_IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end

      RX_DATA: begin
        if (baud_tick) begin
          if (tick_cnt == T_END) begin
            tick_nxt   = '0;
            bit_nxt    = bit_cnt + 1'b1;
            rx_bit_nxt = rx_s;
            shift_nxt  = 1'b1;
            if (bit_cnt == B_LAST) state_nxt = RX_STOP;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end

      RX_STOP: begin
        if (baud_tick) begin
          if (tick_cnt == T_END) begin
            tick_nxt = '0;
            if (rx_s) begin
              done_nxt  = 1'b1;
              state_nxt = RX_IDLE;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = RX_BREAK;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
      end

      // Line held low past the stop bit: wait for it to go idle, tick or not.
      RX_BREAK: begin
        if (rx_s) state_nxt = RX_IDLE;
      end

      default: state_nxt = RX_IDLE;
    endcase

    busy_nxt = (state_nxt != RX_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: table of frames, hand-written corner sequences, random frames vs a byte-level model.
module tb_uart_rx_ctrl;

  localparam int OS = 16;

  typedef bit bitq_t[$];

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    int         div;
    logic [7:0] exp_byte;
    int         exp_done;
    int         exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_line = 1'b1;
  logic baud_tick = 1'b0;
  logic rx_bit, shift, frame_done, framing_err, busy;

  int n_checks = 0;
  int n_fail = 0;
  int div = 1;
  bit abort = 1'b0;

  int cyc = 0;
  bit got_bits[$];
  int shift_cyc[$];
  int n_done = 0, n_err = 0, n_overlap = 0;
  logic prev_shift = 1'b0;

  int b_base, d_base, e_base, o_base;

  uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_line     (rx_line),
    .baud_tick   (baud_tick),
    .rx_bit      (rx_bit),
    .shift       (shift),
    .frame_done  (frame_done),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (cnt == 0);
      cnt = (cnt + 1 >= div) ? 0 : cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (shift) begin
      got_bits.push_back(rx_bit);
      shift_cyc.push_back(cyc);
      if (prev_shift) n_overlap <= n_overlap + 1;
    end
    if (frame_done) n_done <= n_done + 1;
    if (framing_err) n_err <= n_err + 1;
    prev_shift <= shift;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_base = got_bits.size();
    d_base = n_done;
    e_base = n_err;
    o_base = n_overlap;
  endtask

  // Line levels held for whole bit periods; stop_low>0 holds the stop bit low for that many ticks.
  task automatic send_frame(input logic [7:0] d, input int stop_low);
    logic lv[9];
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[i+1] = d[i];
    for (int b = 0; b < 9; b++) begin
      rx_line = lv[b];
      for (int k = 0; k < OS * div; k++) begin
        if (abort) begin
          rx_line = 1'b1;
          return;
        end
        step(1);
      end
    end
    if (stop_low == 0) begin
      rx_line = 1'b1;
      step(OS * div);
    end else begin
      rx_line = 1'b0;
      step(stop_low * div);
      check("busy_held_in_break", busy, 1);
      rx_line = 1'b1;
    end
  endtask

  task automatic check_frames(input string tag, input int nfr, input int exp_done,
                              input int exp_err, input bitq_t exp_bits);
    int n, mism, bad;
    n = got_bits.size() - b_base;
    check({tag, "_shift_count"}, n, nfr * 8);
    mism = 0;
    for (int i = 0; i < exp_bits.size(); i++)
      if (b_base + i < got_bits.size() && got_bits[b_base + i] != exp_bits[i]) mism++;
    check({tag, "_bit_mismatches"}, mism, 0);
    bad = 0;
    for (int i = b_base + 1; i < shift_cyc.size(); i++)
      if (((i - b_base) % 8) != 0 && shift_cyc[i] - shift_cyc[i-1] != OS * div) bad++;
    check({tag, "_shift_spacing_errs"}, bad, 0);
    check({tag, "_frame_done"}, n_done - d_base, exp_done);
    check({tag, "_framing_err"}, n_err - e_base, exp_err);
    check({tag, "_shift_wider_than_1clk"}, n_overlap - o_base, 0);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bitq_t exp;
    logic [7:0] asm_b;
    logic [7:0] rd;
    int sl, t;

    vecs[0] = '{8'hB5, 0, 1, 8'hB5, 1, 0};
    vecs[1] = '{8'h3C, 40, 1, 8'h3C, 0, 1};
    vecs[2] = '{8'h81, 0, 4, 8'h81, 1, 0};
    vecs[3] = '{8'h00, 0, 2, 8'h00, 1, 0};
    vecs[4] = '{8'hFF, 0, 3, 8'hFF, 1, 0};
    vecs[5] = '{8'h6E, 25, 2, 8'h6E, 0, 1};

    // Reset state, with baud_tick high alongside reset.
    reset = 1'b1;
    step(3);
    check("rst_busy", busy, 0);
    check("rst_shift", shift, 0);
    check("rst_rx_bit", rx_bit, 1);
    check("rst_frame_done", frame_done, 0);
    check("rst_framing_err", framing_err, 0);
    reset = 1'b0;
    step(4 * OS);

    foreach (vecs[v]) begin
      div = vecs[v].div;
      step(OS * div);
      mark();
      send_frame(vecs[v].data, vecs[v].stop_low);
      step(2 * OS * div);
      exp.delete();
      for (int i = 0; i < 8; i++) exp.push_back(vecs[v].exp_byte[i]);
      check_frames($sformatf("vec%0d", v), 1, vecs[v].exp_done, vecs[v].exp_err, exp);
      if (got_bits.size() >= b_base + 8) begin
        for (int i = 0; i < 8; i++) asm_b[i] = got_bits[b_base + i];
        check($sformatf("vec%0d_byte", v), asm_b, vecs[v].exp_byte);
      end
    end

    // Start-bit glitch: low 4 ticks, then high.
    div = 1;
    step(2 * OS);
    mark();
    rx_line = 1'b0;
    step(3);
    check("glitch_busy_rises", busy, 1);
    step(1);
    rx_line = 1'b1;
    step(OS / 2 + 3 - 4);
    check("glitch_busy_falls", busy, 0);
    step(2 * OS);
    exp.delete();
    check_frames("glitch", 0, 0, 0, exp);

    // Reset after the third shift of a frame, then a clean frame.
    div = 1;
    mark();
    fork
      send_frame(8'h5A, 0);
      begin
        t = 0;
        while (got_bits.size() - b_base < 3 && t < 2000) begin
          step(1);
          t++;
        end
        check("reset_saw_3_shifts", (got_bits.size() - b_base >= 3) ? 1 : 0, 1);
        reset = 1'b1;
        step(1);
        check("midrst_busy", busy, 0);
        check("midrst_shift", shift, 0);
        check("midrst_rx_bit", rx_bit, 1);
        reset = 1'b0;
        abort = 1'b1;
      end
    join
    abort = 1'b0;
    rx_line = 1'b1;
    step(3 * OS);
    mark();
    send_frame(8'hA5, 0);
    step(2 * OS);
    exp.delete();
    for (int i = 0; i < 8; i++) exp.push_back((8'hA5 >> i) & 1);
    check_frames("after_reset", 1, 1, 0, exp);

    // Back-to-back frames with no idle gap.
    step(OS);
    mark();
    send_frame(8'h00, 0);
    send_frame(8'hFF, 0);
    step(2 * OS);
    exp.delete();
    for (int i = 0; i < 8; i++) exp.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp.push_back(1'b1);
    check_frames("b2b", 2, 2, 0, exp);

    // Random frames against a byte-level model.
    for (int r = 0; r < 16; r++) begin
      rd  = 8'($urandom_range(0, 255));
      div = $urandom_range(1, 3);
      sl  = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : 0;
      step(OS * div + $urandom_range(0, 20));
      mark();
      send_frame(rd, sl);
      step(2 * OS * div);
      exp.delete();
      for (int i = 0; i < 8; i++) exp.push_back(((rd >> i) & 8'd1) != 0);
      check_frames($sformatf("rand%0d", r), 1, (sl == 0) ? 1 : 0, (sl == 0) ? 0 : 1, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
